// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side link between the RX pin/consumer and uart_rx.
//   RX          serial line (idle high), driven from the pin side
//   clr_rdy     consumer acknowledge, clears rdy
//   rx_data     last received byte
//   rdy         sticky byte-valid flag
//   framing_err bad stop bit on the last frame (only with UART_RX_FRAME_ERR_EN)
// master: pin/consumer side. slave: the receiver.
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
`ifdef UART_RX_FRAME_ERR_EN
    logic       framing_err;
`endif

    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy
`ifdef UART_RX_FRAME_ERR_EN
        ,
        input  framing_err
`endif
    );

    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy
`ifdef UART_RX_FRAME_ERR_EN
        ,
        output framing_err
`endif
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line.
// Parameters:
//   BAUD_CYCLES  clocks per bit period (even, >= 16); 2604 = 19200 baud @ 50 MHz
// Ports:
//   clk   single clock
//   rst   asynchronous active-high reset
//   bus   uart_rx_if.slave: RX, clr_rdy in; rx_data, rdy (, framing_err) out
// Optional feature macro: UART_RX_FRAME_ERR_EN adds framing_err, registered
// from the inverted stop bit on frame completion.
module uart_rx #(
    parameter int BAUD_CYCLES = 2604
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int            CW   = $clog2(BAUD_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_CYCLES);
    localparam logic [CW-1:0] HALF = CW'(BAUD_CYCLES / 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, START, RECEIVE} state_t;

    state_t        state, state_nx;
    logic          rx_m, rx_s, rx_prev;
    logic [CW-1:0] baud_cnt, baud_cnt_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic [8:0]    shreg, shreg_nx;
    logic [7:0]    rx_data_r;
    logic          rdy_r;
    logic          fall, start_edge, done;

    // Oldest bit falls off the bottom on each shift and is never needed.
    logic unused_shreg_lsb;
    assign unused_shreg_lsb = shreg[0];

    // Two-flop synchronizer plus one history flop for edge detection; all
    // reset to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= bus.RX;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            shreg    <= shreg_nx;
        end
    end

    // Counters act on the clock where baud_cnt steps from 1 to 0, so a load
    // of N spans exactly N clocks before the sample.
    always_comb begin
        state_nx    = state;
        baud_cnt_nx = baud_cnt;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        start_edge  = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nx    = START;
                    baud_cnt_nx = HALF;
                    bit_cnt_nx  = '0;
                    start_edge  = 1'b1;
                end
            end
            START: begin
                if (baud_cnt == ONE) begin
                    // Mid start bit: a high line means the edge was a glitch.
                    if (rx_s) begin
                        state_nx    = IDLE;
                        baud_cnt_nx = '0;
                    end else begin
                        state_nx    = RECEIVE;
                        baud_cnt_nx = FULL;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt - ONE;
                end
            end
            RECEIVE: begin
                if (baud_cnt == ONE) begin
                    shreg_nx    = {rx_s, shreg[8:1]};
                    bit_cnt_nx  = bit_cnt + 4'd1;
                    baud_cnt_nx = FULL;
                    // Ninth sample is the stop bit, taken mid-bit so IDLE is
                    // back in time for a back-to-back start edge.
                    if (bit_cnt == 4'd8) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt - ONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Completion beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_r <= 8'h00;
            rdy_r     <= 1'b0;
        end else begin
            if (done)
                rx_data_r <= shreg_nx[7:0];
            if (done)
                rdy_r <= 1'b1;
            else if (start_edge || bus.clr_rdy)
                rdy_r <= 1'b0;
        end
    end

    assign bus.rx_data = rx_data_r;
    assign bus.rdy     = rdy_r;

`ifdef UART_RX_FRAME_ERR_EN
    logic ferr_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ferr_r <= 1'b0;
        else if (done)
            ferr_r <= ~shreg_nx[8];
        else if (start_edge || bus.clr_rdy)
            ferr_r <= 1'b0;
    end

    assign bus.framing_err = ferr_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a default-rate instance (2604 clocks/bit) for the reset,
// idle and latency checks, and a fast instance (32 clocks/bit) for framing,
// glitch, reset-mid-frame and randomized traffic.
module tb_uart_rx;

    localparam int BA = 2604;
    localparam int BB = 32;
    localparam int LAT_A = 3 + BA / 2 + 9 * BA;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_if ifa();
    uart_rx_if ifb();

    uart_rx #(.BAUD_CYCLES(BA)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    uart_rx #(.BAUD_CYCLES(BB)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Advance n clocks and land 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) ifb.RX = v;
        else     ifa.RX = v;
    endtask

    // Drive one full 8N1 frame; the receiver's rdy must drop shortly after
    // the start edge whatever it was before.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop);
        int b;
        b = sel ? BB : BA;
        set_rx(sel, 1'b0);
        tick(8);
        chk("rdy_clear_on_start", sel ? ifb.rdy : ifa.rdy, 1'b0);
        tick(b - 8);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            tick(b);
        end
        set_rx(sel, stop);
        tick(b);
    endtask

    initial begin
        int   n;
        logic [7:0] d;

        rst_a = 1'b1; rst_b = 1'b1;
        ifa.RX = 1'b1; ifa.clr_rdy = 1'b0;
        ifb.RX = 1'b1; ifb.clr_rdy = 1'b0;

        vecs.push_back('{8'h00, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{8'h3C, 1'b1, 8'h3C, 1'b0});
`ifdef UART_RX_FRAME_ERR_EN
        vecs.push_back('{8'h42, 1'b0, 8'h42, 1'b1});
        vecs.push_back('{8'hC3, 1'b1, 8'hC3, 1'b0});
`endif

        tick(3);
        chk("reset_rdy_a", ifa.rdy, 1'b0);
        chk("reset_data_a", ifa.rx_data, 8'h00);
        chk("reset_rdy_b", ifb.rdy, 1'b0);
        chk("reset_data_b", ifb.rx_data, 8'h00);
`ifdef UART_RX_FRAME_ERR_EN
        chk("reset_ferr_b", ifb.framing_err, 1'b0);
`endif
        rst_a = 1'b0; rst_b = 1'b0;

        // Idle line after reset: nothing may appear.
        for (int i = 0; i < 100; i++) begin
            tick(100);
            chk("idle_rdy", ifa.rdy | ifb.rdy, 1'b0);
            chk("idle_data", {ifa.rx_data, ifb.rx_data}, 16'h0000);
        end

        // 0xA5 at the default rate, with start-edge-to-rdy latency.
        n = 0;
        fork
            send_frame(1'b0, 8'hA5, 1'b1);
            begin
                while (!ifa.rdy && n < 30000) begin
                    tick(1);
                    n++;
                end
            end
        join
        n_chk++;
        if (n < LAT_A - 2 || n > LAT_A + 2) begin
            n_fail++;
            $display("FAIL latency_a5: got %0d clocks, expected %0d +/- 2", n, LAT_A);
        end
        chk("a5_rdy", ifa.rdy, 1'b1);
        chk("a5_data", ifa.rx_data, 8'hA5);
        ifa.clr_rdy = 1'b1;
        tick(1);
        ifa.clr_rdy = 1'b0;
        chk("a5_clr_rdy", ifa.rdy, 1'b0);
        chk("a5_data_hold", ifa.rx_data, 8'hA5);

        // Table: back-to-back frames, optional framing-error cases.
        foreach (vecs[i]) begin
            send_frame(1'b1, vecs[i].data, vecs[i].stop);
            chk($sformatf("vec%0d_rdy", i), ifb.rdy, 1'b1);
            chk($sformatf("vec%0d_data", i), ifb.rx_data, vecs[i].exp_data);
`ifdef UART_RX_FRAME_ERR_EN
            chk($sformatf("vec%0d_ferr", i), ifb.framing_err, vecs[i].exp_ferr);
`endif
            if (!vecs[i].stop) begin
                ifb.RX = 1'b1;
                tick(2 * BB);
            end
        end
        d = vecs[vecs.size() - 1].exp_data;

        // Short low pulse: rejected at mid start bit.
        ifb.RX = 1'b0;
        tick(BB / 4);
        ifb.RX = 1'b1;
        tick(3 * BB);
        chk("glitch_rdy", ifb.rdy, 1'b0);
        chk("glitch_data", ifb.rx_data, d);
        send_frame(1'b1, 8'h5A, 1'b1);
        chk("after_glitch_rdy", ifb.rdy, 1'b1);
        chk("after_glitch_data", ifb.rx_data, 8'h5A);

        // Reset after four data bits of 0x81.
        d = 8'h81;
        ifb.RX = 1'b0;
        tick(BB);
        for (int i = 0; i < 4; i++) begin
            ifb.RX = d[i];
            tick(BB);
        end
        rst_b = 1'b1;
        #1;
        chk("midreset_rdy", ifb.rdy, 1'b0);
        chk("midreset_data", ifb.rx_data, 8'h00);
        ifb.RX = 1'b1;
        tick(2);
        rst_b = 1'b0;
        tick(2 * BB);
        chk("post_reset_idle_rdy", ifb.rdy, 1'b0);
        send_frame(1'b1, 8'h81, 1'b1);
        chk("post_reset_rdy", ifb.rdy, 1'b1);
        chk("post_reset_data", ifb.rx_data, 8'h81);

        // Random traffic: bytes come out in send order, clr_rdy drops rdy.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] e;
            d = 8'($urandom);
            exp_q.push_back(d);
            send_frame(1'b1, d, 1'b1);
            e = exp_q.pop_front();
            chk($sformatf("rand%0d_rdy", i), ifb.rdy, 1'b1);
            chk($sformatf("rand%0d_data", i), ifb.rx_data, e);
            if ($urandom_range(0, 1) == 1) begin
                ifb.clr_rdy = 1'b1;
                tick(1);
                ifb.clr_rdy = 1'b0;
                chk($sformatf("rand%0d_clr", i), ifb.rdy, 1'b0);
            end
            tick($urandom_range(0, 40));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
